uart_word_tx: RTL and testbench
===============================

# uart_word_tx

Serialises 16-bit words onto a UART line as two 8N1 bytes, low byte first. It is the transmit counterpart of the signal generator's UART word receiver, which assembles a 16-bit control word from two consecutive bytes. It is used to echo and acknowledge settings and to stream status back to the host at 115200 baud from the 50 MHz system clock.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate in bits/s
- CLOCK_50  input  1  system clock; all logic on its rising edge
- arst  input  1  asynchronous, active-high reset
- in_data  input  16  word to send; sampled only on the accepting edge
- tx_start  input  1  request; accepted on a rising edge where tx_start=1 and busy=0
- tx  output  1  serial line, idle high
- busy  output  1  high while a word is in flight
- tx_done  output  1  one-cycle pulse when the high byte's stop bit completes

## Operation
- DIV = CLK_HZ / BAUD, using integer truncation. Default is 434. One bit lasts exactly DIV cycles.
- Byte order: in_data[7:0] first, then in_data[15:8]. Bits within a byte go LSB first.
- Frame per byte: start bit (0), 8 data bits, 1 stop bit (1). No parity.
- The two bytes go back to back with no idle between them: 20 bit periods per word.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on acceptance. On that edge, latch in_data into a 16-bit shift register, clear byte_idx, and restart the divider.
  - START -> DATA after DIV cycles, with bit_idx=0.
  - DATA -> STOP after the 8th bit period, when bit_idx wraps from 7.
  - STOP -> START after DIV cycles if byte_idx=0. Set byte_idx=1 at that point.
  - STOP -> IDLE after DIV cycles if byte_idx=1. Pulse tx_done on that edge.
- tx is a registered output: 0 in START, shift_reg[0] in DATA, 1 in STOP and IDLE.
- tx_start while busy=1 is ignored. in_data is not captured and there is no queuing.
- in_data may change freely after the accepting edge.
- The divider counts 0..DIV-1. The bit-advance tick occurs when count=DIV-1. The divider is held at 0 in IDLE.

## Timing
- Reset values: tx=1, busy=0, tx_done=0, FSM=IDLE, all counters and the shift register 0.
- Reset asserted mid-frame: tx returns to 1 asynchronously and the word is abandoned with no tx_done. After release, the next accepted start sends a complete frame.
- Accept on edge k:
  - tx=0 and busy=1 from edge k+1.
  - The line stays low for DIV cycles.
  - Edge k+1+20·DIV: busy=0, tx_done=1 for that one cycle, tx=1.
- A tx_start high during the tx_done cycle is accepted, because busy=0. The next start bit then begins on the following edge, giving a minimum of 1 idle cycle between words.
- A tx_start held high continuously re-triggers every 20·DIV+1 cycles.
- Widths:
  - Divider width is $clog2(DIV). Elaboration fails if DIV<2.
  - bit_idx is 3 bits and wraps 7->0.
  - byte_idx is 1 bit.

## Structure
- Shared package uart_pkg holds:
  - default CLK_HZ and BAUD,
  - the DIV derivation function,
  - the state encoding constants IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
- The receiver side reuses these constants.
- One sub-module, uart_tx_baud:
  - restartable divider with a clear input,
  - emits a one-cycle tick every DIV cycles while enabled.
- The FSM, shift register and byte sequencing live in uart_word_tx. Total RTL is about 150–200 lines.

## Test plan
1. Reset check (CLK_HZ=16, BAUD=1, so DIV=16): assert arst -> tx=1, busy=0, tx_done=0. Release arst with no start -> outputs unchanged for 1000 cycles.
2. Word 0x12A5 (DIV=16) -> tx carries 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,0,1,0,0,0,1, each bit exactly 16 cycles. busy=1 for 320 cycles. tx_done pulses exactly at accept+321.
3. Start while busy: accept 0x00FF, then pulse tx_start with in_data=0xAAAA at accept+50 -> line shows only 0x00FF (bytes FF, 00). Exactly one tx_done.
4. Back-to-back: hold tx_start=1 with in_data 0x5A5A -> second start bit begins the cycle after tx_done. Exactly 1 idle-high cycle between words. The receiver model decodes 0x5A5A twice.
5. Reset mid-frame: assert arst at accept+100 (inside the low byte's data bits) -> tx=1 in the same cycle, busy=0, no tx_done. After release, send 0xBEEF -> a correct full 320-cycle frame.
6. Default parameters (DIV=434): send 0xFFFF and 0x0000 -> start bit and stop bit each measure exactly 434 cycles. Total busy is 8680 cycles. A 115200-baud receiver model recovers both words.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, divider derivation and the
// FSM state encoding used by both the word transmitter and receiver.
package uart_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    // Cycles per bit, truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Restartable bit-period divider: counts 0..DIV-1 while enabled and emits a
// one-cycle tick on the last count; held at zero when disabled or cleared.
module uart_tx_baud #(
    parameter int DIV = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_baud: DIV must be at least 2");
    end

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Sends a 16-bit word as two back-to-back 8N1 frames, low byte first, with a
// registered line output and a tx_done pulse when the second stop bit ends.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic        CLOCK_50,
    input  logic        arst,
    input  logic [15:0] in_data,
    input  logic        tx_start,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    uart_state_e r_state, w_state_nxt;
    logic [15:0] r_shift, w_shift_nxt;
    logic [2:0]  r_bit_idx, w_bit_idx_nxt;
    logic        r_byte_idx, w_byte_idx_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        w_accept;
    logic        w_tick;

    assign w_accept = tx_start && !r_busy;

    uart_tx_baud #(.DIV(DIV)) u_baud (
        .i_clk  (CLOCK_50),
        .i_rst  (arst),
        .i_clr  (w_accept),
        .i_en   (r_state != IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge CLOCK_50 or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Line value is decided together with the transition so tx changes on the
    // same edge as the state it belongs to.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt    = START;
                    w_shift_nxt    = in_data;
                    w_bit_idx_nxt  = 3'd0;
                    w_byte_idx_nxt = 1'b0;
                    w_tx_nxt       = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_nxt   = {1'b0, r_shift[15:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (!r_byte_idx) begin
                        w_state_nxt    = START;
                        w_byte_idx_nxt = 1'b1;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: a DIV=16 instance for the functional
// scenarios and a default-parameter instance for real-baud timing.
module tb_uart_word_tx;

    logic        clk = 1'b0;
    logic        arst;
    logic        st  [2];
    logic [15:0] din [2];
    logic        txw [2];
    logic        bsy [2];
    logic        dn  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int divs[2] = '{16, 434};

    logic cap_tx[$];
    logic cap_bsy[$];
    logic cap_dn[$];

    always #5 clk = ~clk;

    uart_word_tx #(.CLK_HZ(16), .BAUD(1)) dut_s (
        .CLOCK_50 (clk),
        .arst     (arst),
        .in_data  (din[0]),
        .tx_start (st[0]),
        .tx       (txw[0]),
        .busy     (bsy[0]),
        .tx_done  (dn[0])
    );

    uart_word_tx dut_d (
        .CLOCK_50 (clk),
        .arst     (arst),
        .in_data  (din[1]),
        .tx_start (st[1]),
        .tx       (txw[1]),
        .busy     (bsy[1]),
        .tx_done  (dn[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ideal line level at sample s (s=1 is the first sample after the accepting edge).
    function automatic logic exp_line(input logic [15:0] w, input int div, input int off);
        int b;
        int pos;
        int byte_i;
        b      = (off - 1) / div;
        byte_i = b / 10;
        pos    = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return w[byte_i*8 + pos - 1];
    endfunction

    // Pulse/hold tx_start, then record nc samples of the line and status.
    task automatic run_word(input int d, input logic [15:0] w, input int nc,
                            input int hold_until, input int inj_off, input logic [15:0] inj_w);
        din[d] = w;
        st[d]  = 1'b1;
        tick();
        if (hold_until == 0) begin
            st[d]  = 1'b0;
            din[d] = 16'($urandom);
        end
        cap_tx.delete();
        cap_bsy.delete();
        cap_dn.delete();
        for (int i = 0; i < nc; i++) begin
            cap_tx.push_back(txw[d]);
            cap_bsy.push_back(bsy[d]);
            cap_dn.push_back(dn[d]);
            if (i + 1 == hold_until) st[d] = 1'b0;
            if (i + 1 == inj_off) begin
                st[d]  = 1'b1;
                din[d] = inj_w;
            end else if (i == inj_off) begin
                st[d]  = 1'b0;
            end
            tick();
        end
    endtask

    task automatic check_frames(input string name, input int d, input int nf,
                                input int b0, input logic [15:0] w0,
                                input int b1, input logic [15:0] w1);
        int div;
        int bad_tx, bad_b, bad_d, f_tx;
        logic g_tx, e_tx_first;
        div = divs[d];
        bad_tx = 0; bad_b = 0; bad_d = 0; f_tx = -1;
        g_tx = 1'b0; e_tx_first = 1'b0;
        for (int i = 0; i < cap_tx.size(); i++) begin
            int s, o, b;
            logic etx, eb, ed;
            logic [15:0] w;
            s = i + 1; etx = 1'b1; eb = 1'b0; ed = 1'b0;
            for (int f = 0; f < nf; f++) begin
                b = (f == 0) ? b0 : b1;
                w = (f == 0) ? w0 : w1;
                o = s - b;
                if (o >= 1 && o <= 20*div) begin
                    eb  = 1'b1;
                    etx = exp_line(w, div, o);
                end
                if (o == 20*div + 1) ed = 1'b1;
            end
            if (cap_tx[i] !== etx) begin
                if (f_tx < 0) begin
                    f_tx = s; g_tx = cap_tx[i]; e_tx_first = etx;
                end
                bad_tx++;
            end
            if (cap_bsy[i] !== eb) bad_b++;
            if (cap_dn[i] !== ed) bad_d++;
        end
        n_tests += 3;
        if (bad_tx != 0) begin
            n_fail++;
            $display("FAIL %s tx: %0d wrong samples, first at s=%0d got %b want %b",
                     name, bad_tx, f_tx, g_tx, e_tx_first);
        end
        if (bad_b != 0) begin
            n_fail++;
            $display("FAIL %s busy: %0d wrong samples, want 0", name, bad_b);
        end
        if (bad_d != 0) begin
            n_fail++;
            $display("FAIL %s tx_done: %0d wrong samples, want 0", name, bad_d);
        end
    endtask

    // Receiver model: find the start edge, sample mid-bit at bc cycles per bit.
    task automatic rx_decode(input int from, input real bc, output logic [15:0] w,
                             output int nxt, output bit ok);
        int i, p;
        ok = 1'b1; w = '0; i = from;
        for (int by = 0; by < 2; by++) begin
            while (i < cap_tx.size() && cap_tx[i] !== 1'b0) i++;
            if (i + int'(bc * 10.0) > cap_tx.size()) begin
                ok = 1'b0; nxt = i;
                return;
            end
            for (int k = 1; k <= 8; k++) begin
                p = i + int'($floor(bc * (real'(k) + 0.5)));
                w[by*8 + k - 1] = cap_tx[p];
            end
            p = i + int'($floor(bc * 9.5));
            if (cap_tx[p] !== 1'b1) ok = 1'b0;
            i = p;
        end
        nxt = i;
    endtask

    task automatic check_rx(input string name, input int from, input real bc,
                            input logic [15:0] want, output int nxt);
        logic [15:0] got;
        bit ok;
        rx_decode(from, bc, got, nxt, ok);
        n_tests++;
        if (!ok || got !== want) begin
            n_fail++;
            $display("FAIL %s rx: got %h (framing ok=%0d) want %h", name, got, ok, want);
        end
    endtask

    task automatic test_reset();
        int bad;
        arst = 1'b1;
        #1;
        n_tests += 4;
        if (txw[0] !== 1'b1) begin n_fail++; $display("FAIL reset tx: got %b want 1", txw[0]); end
        if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bsy[0]); end
        if (dn[0] !== 1'b0)  begin n_fail++; $display("FAIL reset tx_done: got %b want 0", dn[0]); end
        if (txw[1] !== 1'b1) begin n_fail++; $display("FAIL reset tx_def: got %b want 1", txw[1]); end
        tick();
        arst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (txw[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_hold: %0d bad cycles want 0", bad); end
    endtask

    task automatic test_word();
        logic [15:0] w;
        int nx;
        for (int r = 0; r < 4; r++) begin
            w = (r == 0) ? 16'h12A5 : 16'($urandom);
            run_word(0, w, 20*16 + 5, 0, -1, 16'h0);
            check_frames($sformatf("word_%h", w), 0, 1, 0, w, 0, 16'h0);
            check_rx($sformatf("word_%h", w), 0, 16.0, w, nx);
            repeat (2) tick();
        end
    endtask

    task automatic test_busy_ignore();
        int dones, nx;
        run_word(0, 16'h00FF, 20*16 + 40, 0, 50, 16'hAAAA);
        check_frames("busy_ignore", 0, 1, 0, 16'h00FF, 0, 16'h0);
        dones = 0;
        foreach (cap_dn[i]) if (cap_dn[i] === 1'b1) dones++;
        n_tests++;
        if (dones != 1) begin n_fail++; $display("FAIL busy_ignore done_count: got %0d want 1", dones); end
        check_rx("busy_ignore", 0, 16.0, 16'h00FF, nx);
    endtask

    task automatic test_back_to_back();
        int nx, nx2, fz;
        run_word(0, 16'h5A5A, 660, 600, -1, 16'h0);
        check_frames("back_to_back", 0, 2, 0, 16'h5A5A, 321, 16'h5A5A);
        fz = 320;
        while (fz < cap_tx.size() && cap_tx[fz] !== 1'b0) fz++;
        n_tests++;
        if (fz + 1 != 322) begin
            n_fail++;
            $display("FAIL b2b second_start: got s=%0d want s=322", fz + 1);
        end
        check_rx("b2b_first", 0, 16.0, 16'h5A5A, nx);
        check_rx("b2b_second", nx, 16.0, 16'h5A5A, nx2);
        repeat (2) tick();
    endtask

    task automatic test_reset_midframe();
        int dones, nx;
        din[0] = 16'($urandom);
        st[0]  = 1'b1;
        tick();
        st[0]  = 1'b0;
        repeat (99) tick();
        arst = 1'b1;
        #1;
        n_tests += 2;
        if (txw[0] !== 1'b1) begin n_fail++; $display("FAIL midreset tx: got %b want 1", txw[0]); end
        if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b want 0", bsy[0]); end
        dones = 0;
        repeat (3) begin
            tick();
            if (dn[0] !== 1'b0) dones++;
        end
        arst = 1'b0;
        repeat (400) begin
            tick();
            if (dn[0] !== 1'b0 || txw[0] !== 1'b1) dones++;
        end
        n_tests++;
        if (dones != 0) begin n_fail++; $display("FAIL midreset quiet: %0d bad cycles want 0", dones); end
        run_word(0, 16'hBEEF, 20*16 + 5, 0, -1, 16'h0);
        check_frames("after_reset_BEEF", 0, 1, 0, 16'hBEEF, 0, 16'h0);
        check_rx("after_reset_BEEF", 0, 16.0, 16'hBEEF, nx);
    endtask

    task automatic test_default();
        real bc;
        int run, nbusy, nx;
        bc = real'(50_000_000) / real'(115_200);
        run_word(1, 16'hFFFF, 20*434 + 5, 0, -1, 16'h0);
        check_frames("def_FFFF", 1, 1, 0, 16'hFFFF, 0, 16'h0);
        run = 0;
        while (run < cap_tx.size() && cap_tx[run] === 1'b0) run++;
        nbusy = 0;
        foreach (cap_bsy[i]) if (cap_bsy[i] === 1'b1) nbusy++;
        n_tests += 2;
        if (run != 434) begin n_fail++; $display("FAIL def start_len: got %0d want 434", run); end
        if (nbusy != 8680) begin n_fail++; $display("FAIL def busy_len: got %0d want 8680", nbusy); end
        check_rx("def_FFFF", 0, bc, 16'hFFFF, nx);
        repeat (2) tick();
        run_word(1, 16'h0000, 20*434 + 5, 0, -1, 16'h0);
        check_frames("def_0000", 1, 1, 0, 16'h0000, 0, 16'h0);
        run = 0;
        for (int i = 9*434; i < cap_tx.size() && cap_tx[i] === 1'b1; i++) run++;
        n_tests++;
        if (run != 434) begin n_fail++; $display("FAIL def stop_len: got %0d want 434", run); end
        check_rx("def_0000", 0, bc, 16'h0000, nx);
    endtask

    initial begin
        arst   = 1'b1;
        st[0]  = 1'b0;
        st[1]  = 1'b0;
        din[0] = '0;
        din[1] = '0;
        repeat (3) tick();
        test_reset();
        test_word();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_default();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
